uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Standalone UART receiver: the receive end of the team's UART link.
- Oversamples the asynchronous `rx` line with the system clock and recovers 8N1/8N2 frames (LSB first); the bit period is set by a clock-per-bit value.
- Delivers each byte through a one-entry holding register with a valid/ready handshake, plus framing and overrun error pulses.
- Sits beside the UART transmitter in the peripheral block, driven by the same CPB/STP configuration registers.

Parameters:
- SYNC_STAGES, 2, number of flops in the `rx` input synchronizer (minimum 2).
- CPB_MIN, 4, smallest honoured clock-per-bit value; smaller `cpb` values are clamped to this.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx  in  1  asynchronous serial input, idles high
- cpb  in  16  clocks per bit (baud divider)
- stp  in  2  stop bits: stp[0]=0 gives 1 stop bit, stp[0]=1 gives 2 stop bits; stp[1] reserved/ignored
- par_odd  in  1  parity sense, 1=odd, 0=even (used only with the macro)
- data_rx  out  8  received byte, valid while rx_valid=1
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts the byte; transfer occurs when rx_valid & rx_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 without the macro)
- overrun  out  1  one-cycle pulse: byte completed while the holding register was still full
- busy  out  1  high in every state except IDLE

Behaviour:
Reset:
- All outputs go to 0, `data_rx`=0, state=IDLE, counters=0.
- Synchronizer flops reset to 1.
- Reset mid-frame aborts the frame with no pulse, and any held byte is lost.

Input handling:
- `rx` passes through SYNC_STAGES flops; every sampling decision below uses the synchronized value `rxs`.
- `cpb` is latched into `cpb_l` on the IDLE→START transition and clamped to CPB_MIN, so changes mid-frame have no effect until the next frame.
- Let half = cpb_l>>1.
- One 16-bit down-counter `cnt` and a 3-bit bit index `idx`.

States:
- IDLE: when `rxs`=0, latch cfg, set cnt=half-1, go to START.
- START: decrement cnt. At cnt=0 (mid start bit):
  - `rxs`=1 means a glitch: return to IDLE with no pulse.
  - Otherwise set cnt=cpb_l-1, idx=0, go to DATA.
- DATA: at cnt=0, shift `rxs` into shift[7] (right-shift, so LSB first). Then:
  - idx=7: go to PARITY (with macro) or STOP1, reload cnt.
  - otherwise idx++ and reload cnt.
- PARITY (macro only): at cnt=0, compare `rxs` with ^shift ^ par_odd, record any mismatch, then go to STOP1.
- STOP1: at cnt=0, sample `rxs`.
  - Low: pulse frame_err, discard the byte, go to BREAK.
  - High with stp[0]=1: go to STOP2.
  - High otherwise: run the delivery step.
- STOP2: same check as STOP1.
- BREAK: wait until `rxs`=1, then go to IDLE. A held-low line produces exactly one frame_err.

Delivery (on the cycle after the final stop-bit sample):
- Parity mismatch: pulse parity_err and discard the byte.
- rx_valid=0, or rx_valid=1 & rx_ready in that same cycle: load data_rx and set rx_valid=1.
- Otherwise: pulse overrun, drop the new byte, keep the old one.
- After delivery, go to IDLE.

Handshake and timing:
- rx_valid clears on the cycle after rx_valid & rx_ready, unless a new byte is loaded in that same cycle.
- Latency: rx_valid rises SYNC_STAGES + half + (9 or 10)·cpb_l + 1 cycles (±1) after the pin's falling edge.
- Delivery happens at mid-stop-bit, so back-to-back frames with no idle gap are received without loss.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: PARITY state inserted after DATA; one parity bit expected; parity sense set by par_odd; a mismatching frame is discarded with a parity_err pulse.
- Undefined: no PARITY state, par_odd ignored, parity_err constant 0, frame is start+8+stop(s).

Test Plan:
- cpb=16, stp=0, rx_ready=1, send 0xA5 → data_rx=0xA5, rx_valid high exactly 1 cycle, ≈156±2 cycles after the falling edge, no error pulses.
- cpb=16, send 0x3C then 0x5A back-to-back with rx_ready=0 → first byte 0x3C held, one overrun pulse; then raise rx_ready → data_rx=0x3C consumed and rx_valid drops.
- cpb=16, 4-cycle low glitch on rx → no rx_valid, busy returns to 0 within 12 cycles, no frame_err.
- cpb=16, send 0x81 with stop bit forced low and line then held low 400 cycles → exactly one frame_err pulse, no rx_valid, busy until the line goes high.
- stp=1, cpb=10, send 0xFF → delivered only after the second stop bit; rx low in the second stop bit → frame_err.
- Macro defined, par_odd=0, send 0x07 with parity bit 1 → data 0x07 delivered; parity bit 0 → parity_err pulse, no rx_valid. Reset asserted mid-frame → all outputs 0 and the next frame is received cleanly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1/8N2 frames delivered through a one-entry holding register.
// Define UART_RX_PARITY_EN to expect a parity bit between the data bits and the stop bit(s).
module uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CPB_MIN     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] cpb,
  input  logic [1:0]  stp,
  input  logic        par_odd,
  output logic [7:0]  data_rx,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overrun,
  output logic        busy
);

  // Handshake: a byte moves to the consumer on any clock edge where rx_valid & rx_ready are both high.
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK, S_DELIVER
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [15:0]            cpb_c;
  logic [15:0]            cpb_l;
  logic [15:0]            cnt;
  logic [2:0]             idx;
  logic [7:0]             shift;
  logic                   two_stop;
  logic                   par_bad;
  logic                   unused_cfg;

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign cpb_c      = (cpb < 16'(CPB_MIN)) ? 16'(CPB_MIN) : cpb;
  assign unused_cfg = ^{stp[1], par_odd};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sync_q     <= '1;
      cpb_l      <= '0;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      two_stop   <= 1'b0;
      par_bad    <= 1'b0;
      data_rx    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            cpb_l    <= cpb_c;
            cnt      <= (cpb_c >> 1) - 16'd1;
            two_stop <= stp[0];
            par_bad  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (rxs) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt   <= cpb_l - 16'd1;
            idx   <= 3'd0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            shift <= {rxs, shift[7:1]};
            cnt   <= cpb_l - 16'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP1;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            par_bad <= (rxs != (^shift ^ par_odd));
            cnt     <= cpb_l - 16'd1;
            state   <= S_STOP1;
          end
        end
`endif
        S_STOP1, S_STOP2: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (!rxs) begin
            frame_err <= 1'b1;
            state     <= S_BREAK;
          end else if (state == S_STOP1 && two_stop) begin
            cnt   <= cpb_l - 16'd1;
            state <= S_STOP2;
          end else begin
            state <= S_DELIVER;
          end
        end
        S_BREAK: begin
          // A line held low raises one frame error, then waits here for idle.
          if (rxs) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_DELIVER: begin
          if (par_bad) begin
            parity_err <= 1'b1;
          end else if (!rx_valid || rx_ready) begin
            data_rx  <= shift;
            rx_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a vector table of single frames plus hand-written
// sequences for overrun, glitch, held-low break and mid-frame reset.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] cpb = 16'd16;
  logic [1:0]  stp = 2'b00;
  logic        par_odd = 1'b0;
  logic        rx_ready = 1'b1;
  logic [7:0]  data_rx;
  logic        rx_valid, frame_err, parity_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  uart_rx #(.SYNC_STAGES(2), .CPB_MIN(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .cpb(cpb), .stp(stp), .par_odd(par_odd),
    .data_rx(data_rx), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor, sampled on the falling edge
  int         mon_vcyc = 0, mon_rise = 0, mon_fe = 0, mon_pe = 0, mon_ov = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) mon_vcyc <= mon_vcyc + 1;
    if (rx_valid && !prev_valid) begin
      mon_rise  <= mon_rise + 1;
      rise_cyc  <= cyc;
      rise_data <= data_rx;
    end
    if (frame_err)  mon_fe <= mon_fe + 1;
    if (parity_err) mon_pe <= mon_pe + 1;
    if (overrun)    mon_ov <= mon_ov + 1;
    prev_valid <= rx_valid;
  end

  // scoreboard counters
  int n_chk = 0, n_pass = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic read_mon(output int v, output int r, output int fe, output int pe, output int ov);
    @(posedge clk); #1;
    v = mon_vcyc; r = mon_rise; fe = mon_fe; pe = mon_pe; ov = mon_ov;
    @(negedge clk);
  endtask

  // driver: caller is at a falling edge; frame bits are held for bp cycles each
  task automatic send_frame(input logic [7:0] d, input int bp, input logic two,
                            input logic [1:0] stop_lo, input logic end_level);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bp) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_odd ^ par_flip;
    repeat (bp) @(negedge clk);
`endif
    rx = ~stop_lo[0];
    repeat (bp) @(negedge clk);
    if (two) begin
      rx = ~stop_lo[1];
      repeat (bp) @(negedge clk);
    end
    rx = end_level;
  endtask

  function automatic int eff_bp(input logic [15:0] c);
    return (c < 16'd4) ? 4 : int'(c);
  endfunction

  typedef struct {
    logic [7:0]  data;
    logic [15:0] cpb;
    logic        two_stop;
    logic [1:0]  stop_lo;
    logic        par_odd;
    logic        par_flip;
    logic        exp_valid;
    int          exp_fe;
    int          exp_pe;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] d, input logic [15:0] c, input logic two,
                              input logic [1:0] slo, input logic po, input logic pf,
                              input logic ev, input int fe, input int pe);
    vec_t v;
    v.data = d; v.cpb = c; v.two_stop = two; v.stop_lo = slo; v.par_odd = po;
    v.par_flip = pf; v.exp_valid = ev; v.exp_fe = fe; v.exp_pe = pe;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int b_v, b_r, b_fe, b_pe, b_ov;
    int c_v, c_r, c_fe, c_pe, c_ov;
    int eff, exp_lat, lat;

    //         data   cpb    2stp  stop_lo odd  flip valid fe pe
    vecs.push_back(mk(8'hA5, 16'd16, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0));
    vecs.push_back(mk(8'h00, 16'd16, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 0, 0));
    vecs.push_back(mk(8'hFF, 16'd10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0));
    vecs.push_back(mk(8'hFF, 16'd10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1, 0));
    vecs.push_back(mk(8'h81, 16'd16, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1, 0));
    vecs.push_back(mk(8'h55, 16'd2,  1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0));
    vecs.push_back(mk(8'h3C, 16'd7,  1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0));
    vecs.push_back(mk(8'hC3, 16'd4,  1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0));
`ifdef UART_RX_PARITY_EN
    vecs.push_back(mk(8'h07, 16'd16, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0));
    vecs.push_back(mk(8'h07, 16'd16, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1));
    vecs.push_back(mk(8'h07, 16'd16, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 0, 0));
    vecs.push_back(mk(8'h6E, 16'd10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 0, 1));
`endif

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({data_rx, rx_valid, frame_err, parity_err, overrun, busy}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_outputs", 32'({data_rx, rx_valid, frame_err, parity_err, overrun, busy}), 32'd0);

    // table-driven single frames with the consumer always ready
    for (int i = 0; i < vecs.size(); i++) begin
      cpb = vecs[i].cpb;
      stp = {1'b0, vecs[i].two_stop};
      par_odd = vecs[i].par_odd;
`ifdef UART_RX_PARITY_EN
      par_flip = vecs[i].par_flip;
`endif
      rx_ready = 1'b1;
      eff = eff_bp(vecs[i].cpb);
      read_mon(b_v, b_r, b_fe, b_pe, b_ov);
      send_frame(vecs[i].data, eff, vecs[i].two_stop, vecs[i].stop_lo, 1'b1);
      repeat (20) @(negedge clk);
      read_mon(c_v, c_r, c_fe, c_pe, c_ov);
      check($sformatf("v%0d_valid_cycles", i), 32'(c_v - b_v), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_bytes", i), 32'(c_r - b_r), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_frame_err", i), 32'(c_fe - b_fe), 32'(vecs[i].exp_fe));
      check($sformatf("v%0d_parity_err", i), 32'(c_pe - b_pe), 32'(vecs[i].exp_pe));
      check($sformatf("v%0d_overrun", i), 32'(c_ov - b_ov), 32'd0);
      check($sformatf("v%0d_busy_idle", i), 32'(busy), 32'd0);
      if (vecs[i].exp_valid) begin
        exp_lat = 2 + eff / 2 + (9 + int'(vecs[i].two_stop) + PAR_BITS) * eff + 1;
        lat = rise_cyc - fall_cyc;
        check($sformatf("v%0d_data", i), 32'(rise_data), 32'(vecs[i].data));
        check($sformatf("v%0d_latency_%0d_near_%0d", i, lat, exp_lat),
              32'(lat >= exp_lat - 2 && lat <= exp_lat + 2), 32'd1);
      end
    end
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    par_odd = 1'b0;
    cpb = 16'd16;
    stp = 2'b00;

    // back-to-back frames into a full holding register
    rx_ready = 1'b0;
    read_mon(b_v, b_r, b_fe, b_pe, b_ov);
    send_frame(8'h3C, 16, 1'b0, 2'b00, 1'b1);
    send_frame(8'h5A, 16, 1'b0, 2'b00, 1'b1);
    repeat (20) @(negedge clk);
    read_mon(c_v, c_r, c_fe, c_pe, c_ov);
    check("b2b_held_valid", 32'(rx_valid), 32'd1);
    check("b2b_held_data", 32'(data_rx), 32'h3C);
    check("b2b_overrun", 32'(c_ov - b_ov), 32'd1);
    check("b2b_bytes", 32'(c_r - b_r), 32'd1);
    check("b2b_frame_err", 32'(c_fe - b_fe), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    check("b2b_consumed", 32'(rx_valid), 32'd0);

    // 4-cycle glitch on an idle line
    read_mon(b_v, b_r, b_fe, b_pe, b_ov);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_rise", 32'(busy), 32'd1);
    @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_fall", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    read_mon(c_v, c_r, c_fe, c_pe, c_ov);
    check("glitch_bytes", 32'(c_r - b_r), 32'd0);
    check("glitch_frame_err", 32'(c_fe - b_fe), 32'd0);

    // stop bit low, then the line held low for 400 cycles
    read_mon(b_v, b_r, b_fe, b_pe, b_ov);
    send_frame(8'h81, 16, 1'b0, 2'b01, 1'b0);
    repeat (400) @(negedge clk);
    read_mon(c_v, c_r, c_fe, c_pe, c_ov);
    check("break_busy_held", 32'(busy), 32'd1);
    check("break_frame_err_once", 32'(c_fe - b_fe), 32'd1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("break_busy_release", 32'(busy), 32'd0);
    read_mon(c_v, c_r, c_fe, c_pe, c_ov);
    check("break_frame_err_total", 32'(c_fe - b_fe), 32'd1);
    check("break_bytes", 32'(c_r - b_r), 32'd0);

    // held byte plus a partial frame, wiped by reset
    rx_ready = 1'b0;
    send_frame(8'h11, 16, 1'b0, 2'b00, 1'b1);
    repeat (20) @(negedge clk);
    check("pre_reset_held", 32'({rx_valid, data_rx}), 32'h111);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("midframe_reset_outputs",
          32'({data_rx, rx_valid, frame_err, parity_err, overrun, busy}), 32'd0);
    rst = 1'b0;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    read_mon(b_v, b_r, b_fe, b_pe, b_ov);
    send_frame(8'h96, 16, 1'b0, 2'b00, 1'b1);
    repeat (20) @(negedge clk);
    read_mon(c_v, c_r, c_fe, c_pe, c_ov);
    check("post_reset_bytes", 32'(c_r - b_r), 32'd1);
    check("post_reset_data", 32'(rise_data), 32'h96);
    check("post_reset_errors", 32'((c_fe - b_fe) + (c_pe - b_pe) + (c_ov - b_ov)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
